counter_machine_core: RTL
=========================

Name: counter_machine_core

Overview:
Parametrised N-register counter-machine processor: the next generation of the team's two-counter machine. It runs from a single 50 MHz clock using a clock-enable tick instead of a derived clock. It adds a single-step mode, a registered program-ROM fetch port, saturating counters with a sticky overflow flag, and a retired-instruction counter. Its host is the board top level, which provides the program ROM, the step button and the debug displays.

Parameters:
DATA_W, 8, width of each counter register
NUM_REGS, 4, number of counter registers (power of 2, 2..32)
PC_W, 8, program counter / ROM address width
TICK_DIV, 25_000_000, clk50mhz cycles per run-mode advance tick (>=2)
RET_W, 16, retired-instruction counter width

Ports:
clk50mhz  in  1  system clock
reset  in  1  synchronous, active-low
run_mode  in  1  1 = free-run on tick; 0 = single-step on step_btn
step_btn  in  1  asynchronous pushbutton, active-high
imem_addr  out  PC_W  program ROM address
imem_data  in  16  ROM word; valid the cycle after imem_addr is presented
dbg_sel  in  log2(NUM_REGS)  register select for dbg_data
dbg_data  out  DATA_W  combinational read of reg[dbg_sel]
pc_out  out  PC_W  current PC
halted  out  1  high in HALT state
overflow  out  1  sticky; set by INC at max value
retired  out  RET_W  count of executed instructions

Behaviour:
- Reset: reset==0 at a clk50mhz edge clears the following:
  - pc, all regs, retired, overflow, halted, tick counter, step synchroniser;
  - imem_addr=0; FSM=WAIT.
  - A reset in any state, including mid-FETCH/EXEC, aborts the instruction. No register write occurs in that cycle.
- Tick: counter 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0. Runs continuously, independent of mode.
- step_btn: 2-FF synchroniser plus rising-edge detect giving a one-cycle step_pulse.
- advance = run_mode ? tick : step_pulse.
- FSM:
  - WAIT: on advance, go to FETCH. imem_addr is driven from pc in all states.
  - FETCH: one cycle for the ROM read; go to EXEC.
  - EXEC: decode imem_data and commit, then go to WAIT, or to HALT for opcode HALT.
  - HALT: stays until reset. advance is ignored.
- advance arriving in FETCH/EXEC/HALT is dropped, not queued.
- A run_mode change mid-instruction lets the current instruction complete.
- Instruction encoding, imem_data[15:0]:
  - [15:13] opcode.
  - [12:8] register index; the low log2(NUM_REGS) bits are used, upper bits ignored.
  - [7:0] signed offset.
- Opcodes:
  - 000 NOP: pc+1.
  - 001 INC r: if reg==2^DATA_W-1, reg holds and overflow<=1; else reg+1. pc+1.
  - 010 DEC r: reg-1, saturating at 0 (DEC of 0 leaves 0). pc+1.
  - 011 JZ r,off: if reg==0, pc<=pc+sign_extend(off); else pc+1.
  - 100 JMP off: pc<=pc+sign_extend(off).
  - 101 HALT: pc unchanged; halted<=1.
  - 110/111: treated as NOP.
- PC arithmetic is modulo 2^PC_W; wrap-around is legal. Offset 0 on a taken jump is a legal self-loop.
- retired increments in every EXEC, including HALT. It saturates at all-ones.
- Latency: an instruction commits 2 cycles after advance. The first instruction after reset executes on the first advance.
- dbg_data reflects the register value updated in EXEC from the following cycle.

Test Plan:
- TICK_DIV=4, run_mode=1, program INC r0 ×3; HALT -> r0=3 and halted=1 after 4 ticks; retired=4; pc frozen at 3; further ticks change nothing.
- Program DEC r1; JZ r1,+2; INC r2; HALT with r1=0 -> r1 stays 0, jump taken, r2=0, halted at pc=3.
- DATA_W=4, INC r0 ×16 -> r0=15 and overflow=1 on the 16th INC. overflow stays 1 through NOP; cleared only by reset.
- run_mode=0, with a step_btn press held 10 cycles and a second press during FETCH -> exactly one instruction executes per clean press; the mid-instruction press is dropped.
- JMP -1 at pc=0 with PC_W=8 -> pc=255 (wrap); JZ off=0 on a zero register -> self-loop with retired incrementing each advance.
- Assert reset=0 during EXEC of INC r0 -> r0=0, pc=0, retired=0 next cycle; execution restarts from 0 on the next advance.

Source files
------------

// File: rtl/counter_machine_core.sv
// Counter-machine core: NUM_REGS saturating counters, PC-relative jumps, tick-paced
// free run or synchronised single-step, sticky overflow and a retired-instruction count.
module counter_machine_core #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int PC_W     = 8,
  parameter int TICK_DIV = 25_000_000,
  parameter int RET_W    = 16,
  localparam int REG_W   = $clog2(NUM_REGS)
) (
  input  logic              clk50mhz,
  input  logic              reset,
  input  logic              run_mode,
  input  logic              step_btn,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  input  logic [REG_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted,
  output logic              overflow,
  output logic [RET_W-1:0]  retired
);

  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_JZ   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {
    S_WAIT,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [1:0]          sync_q, sync_d;
  logic                step_prev_q, step_prev_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                overflow_q, overflow_d;
  logic                halted_q, halted_d;
  logic [RET_W-1:0]    retired_q, retired_d;

  logic                tick;
  logic                step_pulse;
  logic                advance;
  logic [2:0]          opcode;
  logic [REG_W-1:0]    reg_idx;
  logic [PC_W-1:0]     offset;
  logic [DATA_W-1:0]   cur;

  // Index bits above REG_W are don't-care, so the word is folded here.
  logic unused_imem;
  assign unused_imem = ^imem_data;

  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    sync_d      = {sync_q[0], step_btn};
    step_prev_d = sync_q[1];
    step_pulse  = sync_q[1] & ~step_prev_q;
    advance     = run_mode ? tick : step_pulse;

    opcode  = imem_data[15:13];
    reg_idx = imem_data[8 +: REG_W];
    offset  = PC_W'($signed(imem_data[7:0]));
    cur     = regs_q[reg_idx];
  end

  // Advance requests are only honoured in WAIT; anything arriving mid-instruction is lost.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    regs_d     = regs_q;
    overflow_d = overflow_q;
    halted_d   = halted_q;
    retired_d  = retired_q;

    case (state_q)
      S_WAIT:  if (advance) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WAIT;
        pc_d    = pc_q + PC_W'(1);
        if (retired_q != '1) retired_d = retired_q + RET_W'(1);
        case (opcode)
          OP_INC: begin
            if (cur == '1) overflow_d = 1'b1;
            else regs_d[reg_idx] = cur + DATA_W'(1);
          end
          OP_DEC: begin
            if (cur != '0) regs_d[reg_idx] = cur - DATA_W'(1);
          end
          OP_JZ: begin
            if (cur == '0) pc_d = pc_q + offset;
          end
          OP_JMP: pc_d = pc_q + offset;
          OP_HALT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk50mhz) begin
    if (!reset) begin
      state_q     <= S_WAIT;
      tick_cnt_q  <= '0;
      sync_q      <= '0;
      step_prev_q <= 1'b0;
      pc_q        <= '0;
      regs_q      <= '{default: '0};
      overflow_q  <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      sync_q      <= sync_d;
      step_prev_q <= step_prev_d;
      pc_q        <= pc_d;
      regs_q      <= regs_d;
      overflow_q  <= overflow_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign halted    = halted_q;
  assign overflow  = overflow_q;
  assign retired   = retired_q;
  assign dbg_data  = regs_q[dbg_sel];

endmodule
